// File: rtl/ee201_numlock_pkg.sv
// Shared types and constants for the number-lock code sender and its benches.
package ee201_numlock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        RELEASE,
        WAIT_RESP,
        DONE,
        COOLDOWN
    } state_t;

    localparam int RETRY_COOLDOWN   = 8;

    localparam int DEF_CODE_LEN     = 4;
    localparam int DEF_HOLD_CYCLES  = 3;
    localparam int DEF_GAP_CYCLES   = 2;
    localparam int DEF_RESP_TIMEOUT = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ee201_numlock_code_sender_if.sv
// Button/handshake bundle between the code sender and its requester/lock.
// EE201_NUMLOCK_SENDER_RETRY_EN adds the attempt indicator.
interface ee201_numlock_code_sender_if #(parameter int CODE_LEN = 4);
    logic                start;
    logic [CODE_LEN-1:0] code;
    logic                lock_opening;
    logic                lock_bad;
    logic                u;
    logic                z;
    logic                busy;
    logic                done;
    logic                opened;
    logic                failed;
`ifdef EE201_NUMLOCK_SENDER_RETRY_EN
    logic                attempt;

    modport master (input start, code, lock_opening, lock_bad,
                    output u, z, busy, done, opened, failed, attempt);
    modport slave  (output start, code, lock_opening, lock_bad,
                    input u, z, busy, done, opened, failed, attempt);
`else
    modport master (input start, code, lock_opening, lock_bad,
                    output u, z, busy, done, opened, failed);
    modport slave  (output start, code, lock_opening, lock_bad,
                    input u, z, busy, done, opened, failed);
`endif
endinterface

// File: rtl/ee201_numlock_press_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module ee201_numlock_press_timer #(
    parameter int W = 5
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)          cnt <= '0;
        else if (load)      cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/ee201_numlock_code_sender.sv
// Enters a latched combination on the lock's u/z buttons, MSB first, and reports the verdict.
// EE201_NUMLOCK_SENDER_RETRY_EN enables one cooled-down retry after a failed attempt.
module ee201_numlock_code_sender
    import ee201_numlock_pkg::*;
#(
    parameter int CODE_LEN     = DEF_CODE_LEN,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
    input  logic Clk,
    input  logic reset,
    ee201_numlock_code_sender_if.master bus
);
`ifdef EE201_NUMLOCK_SENDER_RETRY_EN
    localparam int TMAX = max3(max3(HOLD_CYCLES, GAP_CYCLES, RESP_TIMEOUT), RETRY_COOLDOWN, 1);
`else
    localparam int TMAX = max3(HOLD_CYCLES, GAP_CYCLES, RESP_TIMEOUT);
`endif
    localparam int CW = $clog2(TMAX) + 1;
    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    state_t              state, state_n;
    logic [CODE_LEN-1:0] code_q, code_n;
    logic [IW-1:0]       idx, idx_n;
    logic                u_q, z_q, busy_q, done_q, opened_q, failed_q;
    logic                tmr_load, tmr_tc, fail_ev, set_open, set_fail, clr_res;
    logic [CW-1:0]       tmr_val;
`ifdef EE201_NUMLOCK_SENDER_RETRY_EN
    logic                attempt_q, attempt_n;
`endif

    ee201_numlock_press_timer #(.W(CW)) u_timer (
        .Clk      (Clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_n  = state;
        code_n   = code_q;
        idx_n    = idx;
        tmr_load = 1'b0;
        tmr_val  = '0;
        fail_ev  = 1'b0;
        set_open = 1'b0;
        set_fail = 1'b0;
        clr_res  = 1'b0;
`ifdef EE201_NUMLOCK_SENDER_RETRY_EN
        attempt_n = attempt_q;
`endif
        case (state)
            IDLE: if (bus.start) begin
                code_n   = bus.code;
                idx_n    = IW'(CODE_LEN - 1);
                clr_res  = 1'b1;
                state_n  = PRESS;
                tmr_load = 1'b1;
                tmr_val  = CW'(HOLD_CYCLES - 1);
`ifdef EE201_NUMLOCK_SENDER_RETRY_EN
                attempt_n = 1'b0;
`endif
            end
            PRESS: begin
                if (bus.lock_bad) fail_ev = 1'b1;
                else if (tmr_tc) begin
                    state_n  = RELEASE;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(GAP_CYCLES - 1);
                end
            end
            RELEASE: begin
                if (bus.lock_bad) fail_ev = 1'b1;
                else if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (idx == '0) begin
                        state_n = WAIT_RESP;
                        tmr_val = CW'(RESP_TIMEOUT - 1);
                    end else begin
                        idx_n   = idx - 1'b1;
                        state_n = PRESS;
                        tmr_val = CW'(HOLD_CYCLES - 1);
                    end
                end
            end
            WAIT_RESP: begin
                // bad outranks opening when both arrive together
                if (bus.lock_bad) fail_ev = 1'b1;
                else if (bus.lock_opening) begin
                    set_open = 1'b1;
                    state_n  = DONE;
                end else if (tmr_tc) fail_ev = 1'b1;
            end
`ifdef EE201_NUMLOCK_SENDER_RETRY_EN
            COOLDOWN: if (tmr_tc) begin
                idx_n    = IW'(CODE_LEN - 1);
                state_n  = PRESS;
                tmr_load = 1'b1;
                tmr_val  = CW'(HOLD_CYCLES - 1);
            end
`endif
            default: state_n = IDLE;
        endcase

        if (fail_ev) begin
`ifdef EE201_NUMLOCK_SENDER_RETRY_EN
            if (!attempt_q) begin
                attempt_n = 1'b1;
                state_n   = COOLDOWN;
                tmr_load  = 1'b1;
                tmr_val   = CW'(RETRY_COOLDOWN - 1);
            end else begin
                set_fail = 1'b1;
                state_n  = DONE;
            end
`else
            set_fail = 1'b1;
            state_n  = DONE;
`endif
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Outputs are registered from next-state so buttons rise on the edge that enters PRESS.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            code_q   <= '0;
            idx      <= '0;
            u_q      <= 1'b0;
            z_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            opened_q <= 1'b0;
            failed_q <= 1'b0;
        end else begin
            code_q   <= code_n;
            idx      <= idx_n;
            u_q      <= (state_n == PRESS) &&  code_n[idx_n];
            z_q      <= (state_n == PRESS) && !code_n[idx_n];
            busy_q   <= (state_n != IDLE) && (state_n != DONE);
            done_q   <= (state_n == DONE);
            opened_q <= !clr_res && (opened_q || set_open);
            failed_q <= !clr_res && (failed_q || set_fail);
        end
    end

`ifdef EE201_NUMLOCK_SENDER_RETRY_EN
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) attempt_q <= 1'b0;
        else       attempt_q <= attempt_n;
    end
    assign bus.attempt = attempt_q;
`endif

    assign bus.u      = u_q;
    assign bus.z      = z_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.opened = opened_q;
    assign bus.failed = failed_q;
endmodule

// File: tb/tb_ee201_numlock_code_sender.sv
// Directed bench for the code sender; cycle c is the period after the c-th edge following start.
module tb_ee201_numlock_code_sender;
    logic Clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ee201_numlock_code_sender_if #(.CODE_LEN(4)) bus_if ();

    ee201_numlock_code_sender dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int c, input logic eu, input logic ez,
                            input logic eb, input logic ed, input logic eo, input logic ef);
        chk($sformatf("%s u c%0d", tag, c),      bus_if.u,      eu);
        chk($sformatf("%s z c%0d", tag, c),      bus_if.z,      ez);
        chk($sformatf("%s busy c%0d", tag, c),   bus_if.busy,   eb);
        chk($sformatf("%s done c%0d", tag, c),   bus_if.done,   ed);
        chk($sformatf("%s opened c%0d", tag, c), bus_if.opened, eo);
        chk($sformatf("%s failed c%0d", tag, c), bus_if.failed, ef);
    endtask

    function automatic logic pressed(input int r);
        return (r >= 1 && r <= 3) || (r >= 6 && r <= 8) || (r >= 11 && r <= 13) || (r >= 16 && r <= 18);
    endfunction

    initial begin
        bit seen;
        bus_if.start        = 1'b0;
        bus_if.code         = 4'b0000;
        bus_if.lock_opening = 1'b0;
        bus_if.lock_bad     = 1'b0;

        @(negedge Clk);
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // code 1011, spurious opening during a gap, real opening at cycle 23
        @(negedge Clk);
        bus_if.start = 1'b1;
        bus_if.code  = 4'b1011;
        for (int c = 1; c <= 26; c++) begin
            @(negedge Clk);
            chk_outs("open", c,
                     (c >= 1 && c <= 3) || (c >= 11 && c <= 13) || (c >= 16 && c <= 18),
                     (c >= 6 && c <= 8), (c <= 23), (c == 24), (c >= 24), 0);
            bus_if.start        = 1'b0;
            bus_if.lock_opening = (c == 9) || (c == 23);
        end

`ifndef EE201_NUMLOCK_SENDER_RETRY_EN
        // code 0000 times out; start while busy ignored; start held across DONE starts code 1000,
        // which is aborted by lock_bad in its second press (code not re-latched by a busy start)
        @(negedge Clk);
        bus_if.start = 1'b1;
        bus_if.code  = 4'b0000;
        for (int c = 1; c <= 47; c++) begin
            @(negedge Clk);
            if (c <= 37)
                chk_outs("tmo", c, 0, pressed(c), (c <= 36), (c == 37), 0, (c >= 37));
            else if (c == 38)
                chk_outs("tmo", c, 0, 0, 0, 0, 0, 1);
            else
                chk_outs("abort", c - 38, (c - 38 <= 3), (c - 38 == 6) || (c - 38 == 7),
                         (c - 38 <= 7), (c - 38 == 8), 0, (c - 38 >= 8));
            bus_if.start    = (c == 10) || (c == 37) || (c == 38) || (c == 41);
            if (c == 10 || c == 41) bus_if.code = 4'b1111;
            if (c == 37)            bus_if.code = 4'b1000;
            bus_if.lock_bad = (c == 45);
        end

        // bad and opening together in WAIT_RESP: bad wins
        @(negedge Clk);
        bus_if.start = 1'b1;
        bus_if.code  = 4'b0001;
        for (int c = 1; c <= 24; c++) begin
            @(negedge Clk);
            chk_outs("both", c, (c >= 16 && c <= 18), pressed(c) && !(c >= 16 && c <= 18),
                     (c <= 22), (c == 23), 0, (c >= 23));
            bus_if.start        = 1'b0;
            bus_if.lock_bad     = (c == 22);
            bus_if.lock_opening = (c == 22);
        end
`else
        // first attempt times out, cooldown 37..44, retry presses from 45, opening at 66
        @(negedge Clk);
        bus_if.start = 1'b1;
        bus_if.code  = 4'b0000;
        for (int c = 1; c <= 68; c++) begin
            @(negedge Clk);
            chk_outs("retry", c, 0, pressed(c) || pressed(c - 44), (c <= 66), (c == 67), (c >= 67), 0);
            chk($sformatf("retry attempt c%0d", c), bus_if.attempt, (c >= 37));
            bus_if.start        = 1'b0;
            bus_if.lock_opening = (c == 66);
        end
`endif

        // asynchronous reset in the middle of a press, then a fresh request
        @(negedge Clk);
        bus_if.start = 1'b1;
        bus_if.code  = 4'b1111;
        @(negedge Clk);
        bus_if.start = 1'b0;
        chk("rst pre u", bus_if.u, 1'b1);
        @(negedge Clk);
        #2 reset = 1'b1;
        #1;
        chk("rst u", bus_if.u, 1'b0);
        chk("rst z", bus_if.z, 1'b0);
        chk("rst busy", bus_if.busy, 1'b0);
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        bus_if.start = 1'b1;
        bus_if.code  = 4'b0100;
        for (int c = 1; c <= 7; c++) begin
            @(negedge Clk);
            bus_if.start = 1'b0;
            chk($sformatf("post u c%0d", c), bus_if.u, (c == 6) || (c == 7));
            chk($sformatf("post z c%0d", c), bus_if.z, (c <= 3));
            chk($sformatf("post busy c%0d", c), bus_if.busy, 1'b1);
        end
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge Clk);
            if (bus_if.done) seen = 1'b1;
        end
        chk("post done seen", seen, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    always @(negedge Clk) begin
        if (bus_if.u === 1'b1 && bus_if.z === 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL u_z_exclusive: got u=1 z=1 want at most one high");
        end
    end
endmodule
